krazace_seq: RTL and testbench
==============================

KRAZACE_SEQ -- requirements
Module: krazace_seq

Interface
REQ-001 SHALL have parameter BITS_NUM, default 27: prescaler counter width.
REQ-002 SHALL have parameter MOD_BASE, default 100000: CE cycles per step at the fastest speed.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port CLR  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CE  input  1  clock enable for the prescaler and the pattern.
REQ-006 SHALL have port BTN_MODE  input  1  level button, already synchronized; a rising edge advances the mode.
REQ-007 SHALL have port BTN_FAST  input  1  level button; a rising edge increments speed.
REQ-008 SHALL have port BTN_SLOW  input  1  level button; a rising edge decrements speed.
REQ-009 SHALL have port Q  output  4  running-light pattern, registered.
REQ-010 SHALL have port MODE  output  2  current mode: 0=STOP, 1=LEFT, 2=RIGHT, 3=BOUNCE.
REQ-011 SHALL have port SPEED  output  3  speed: 0 slowest, 7 fastest.
REQ-012 SHALL have port TICK  output  1  one-cycle pulse on each pattern step.

Function
REQ-013 SHALL detect rising edges on each button by comparing it with a registered previous sample, every CLK cycle, independent of CE.
REQ-014 SHALL advance MODE on a BTN_MODE edge: STOP->LEFT->RIGHT->BOUNCE->STOP.
REQ-015 SHALL, on every mode change, load Q=4'b0001, set bounce direction to "up" and clear the prescaler in the same cycle.
REQ-016 SHALL increment SPEED on a BTN_FAST edge, saturating at 7.
REQ-017 SHALL decrement SPEED on a BTN_SLOW edge, saturating at 0.
REQ-018 SHALL leave SPEED unchanged when BTN_FAST and BTN_SLOW edges occur in the same cycle.
REQ-019 SHALL apply mode and speed edges that occur in the same cycle independently.
REQ-020 SHALL define the step period P = MOD_BASE*(8-SPEED) CE cycles; BITS_NUM must hold 8*MOD_BASE-1.
REQ-021 SHALL, when CE=1 and MODE!=STOP, increment the prescaler; when count >= P-1, clear it and assert TICK for one cycle.
REQ-022 SHALL use the >= compare so that a speed increase mid-period never skips a terminal count.
REQ-023 SHALL, when CE=0, hold the prescaler, Q and TICK=0.
REQ-024 SHALL, in STOP, hold the prescaler at 0 and Q constant, with TICK never asserted.
REQ-025 SHALL update Q on TICK as follows: LEFT rotates left (bit3 wraps to bit0); RIGHT rotates right (bit0 wraps to bit3).
REQ-026 SHALL update Q on TICK in BOUNCE by shifting a single lit bit: up shifts left, down shifts right.
REQ-027 SHALL, in BOUNCE, reverse direction to down when Q reaches 4'b1000 and to up when Q reaches 4'b0001, so no step is repeated at either end.
REQ-028 SHALL give a mode-change edge priority over a coincident TICK: the pattern loads 4'b0001 and no step is taken.

Reset
REQ-029 SHALL, on CLR=1 at a clock edge, set Q=4'b0001, MODE=STOP, SPEED=0, TICK=0, prescaler=0 and direction=up.
REQ-030 SHALL reset the button previous-sample registers to 1, so a button held through reset produces no edge after release.
REQ-031 SHALL give CLR priority over CE and all button edges.

Structure
REQ-032 SHALL place the mode encodings (STOP, LEFT, RIGHT, BOUNCE) and SPEED_MAX=7 in a shared package, krazace_pkg.
REQ-033 SHALL implement edge detection as a sub-module EDGE_DET, instantiated three times.
REQ-034 SHALL implement the prescaler, mode FSM and pattern register inside krazace_seq.

Verification (MOD_BASE=2 in simulation)
REQ-035 Bench SHALL cover LEFT mode: CLR, then one BTN_MODE edge, then 7 FAST edges, then CE=1 -> Q steps every 2 cycles: 0001,0010,0100,1000,0001, with one TICK per step.
REQ-036 Bench SHALL cover RIGHT mode: second BTN_MODE edge -> Q=0001 immediately, then 1000,0100,0010,0001.
REQ-037 Bench SHALL cover BOUNCE mode: third BTN_MODE edge -> Q=0001,0010,0100,1000,0100,0010,0001,0010.
REQ-038 Bench SHALL cover speed limits: 9 FAST edges -> SPEED=7; SLOW edge at SPEED=0 -> 0; simultaneous FAST+SLOW at SPEED=3 -> 3; SPEED=0 gives 16 cycles per step.
REQ-039 Bench SHALL cover CE and STOP: CE=0 for 10 cycles mid-LEFT -> Q and prescaler frozen, TICK=0; in STOP with CE=1 -> Q constant, no TICK.
REQ-040 Bench SHALL cover reset mid-operation: CLR mid-BOUNCE at Q=0100 -> next cycle Q=0001, MODE=0, SPEED=0; BTN_MODE held high across CLR release -> MODE stays 0.

Source files
------------

// File: rtl/krazace_pkg.sv
// Shared encodings and pattern helpers for the krazace running-light sequencer.
package krazace_pkg;

    localparam logic [1:0] MODE_STOP   = 2'd0;
    localparam logic [1:0] MODE_LEFT   = 2'd1;
    localparam logic [1:0] MODE_RIGHT  = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic [2:0] SPEED_MAX  = 3'd7;
    localparam logic [2:0] SPEED_MIN  = 3'd0;
    localparam logic [3:0] PAT_INIT   = 4'b0001;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    function automatic logic [3:0] rot_left(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    function automatic logic [3:0] rot_right(input logic [3:0] v);
        return {v[0], v[3:1]};
    endfunction

endpackage

// File: rtl/EDGE_DET.sv
// Rising-edge detector for an already-synchronised level input.
module EDGE_DET (
    input  logic CLK,
    input  logic CLR,
    input  logic D,
    output logic RISE
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = D;
        RISE   = D & ~prev_q;
    end

    // Previous sample resets high so a button held through reset yields no edge.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/krazace_seq.sv
// Running-light sequencer: button-driven mode/speed control, CE-gated prescaler, 4-bit pattern.
module krazace_seq
    import krazace_pkg::*;
#(
    parameter int unsigned BITS_NUM = 27,
    parameter int unsigned MOD_BASE = 100000
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE,
    input  logic       BTN_MODE,
    input  logic       BTN_FAST,
    input  logic       BTN_SLOW,
    output logic [3:0] Q,
    output logic [1:0] MODE,
    output logic [2:0] SPEED,
    output logic       TICK
);

    logic mode_rise;
    logic fast_rise;
    logic slow_rise;

    EDGE_DET u_edge_mode (
        .CLK  (CLK),
        .CLR  (CLR),
        .D    (BTN_MODE),
        .RISE (mode_rise)
    );

    EDGE_DET u_edge_fast (
        .CLK  (CLK),
        .CLR  (CLR),
        .D    (BTN_FAST),
        .RISE (fast_rise)
    );

    EDGE_DET u_edge_slow (
        .CLK  (CLK),
        .CLR  (CLR),
        .D    (BTN_SLOW),
        .RISE (slow_rise)
    );

    logic [BITS_NUM-1:0] cnt_q, cnt_d;
    logic [3:0]          q_q, q_d;
    logic [1:0]          mode_q, mode_d;
    logic [2:0]          speed_q, speed_d;
    logic                tick_q, tick_d;
    dir_e                dir_q, dir_d;

    logic [31:0]         period;
    logic [BITS_NUM-1:0] term_cnt;

    // Terminal count uses the current speed; >= keeps a mid-period speed-up from overshooting.
    always_comb begin
        period   = MOD_BASE * (32'd8 - 32'(speed_q));
        term_cnt = BITS_NUM'(period - 32'd1);
    end

    always_comb begin
        speed_d = speed_q;
        if (fast_rise && !slow_rise && speed_q != SPEED_MAX) begin
            speed_d = speed_q + 3'd1;
        end else if (slow_rise && !fast_rise && speed_q != SPEED_MIN) begin
            speed_d = speed_q - 3'd1;
        end
        mode_d = mode_rise ? mode_q + 2'd1 : mode_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        if (mode_rise) begin
            // A mode change restarts the pattern and swallows any coincident step.
            cnt_d = '0;
            q_d   = PAT_INIT;
            dir_d = DirUp;
        end else if (mode_q == MODE_STOP) begin
            cnt_d = '0;
        end else if (CE) begin
            if (cnt_q >= term_cnt) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                unique case (mode_q)
                    MODE_LEFT:  q_d = rot_left(q_q);
                    MODE_RIGHT: q_d = rot_right(q_q);
                    MODE_BOUNCE: begin
                        if (dir_q == DirUp) begin
                            q_d = q_q << 1;
                            if (q_q[2]) begin
                                dir_d = DirDown;
                            end
                        end else begin
                            q_d = q_q >> 1;
                            if (q_q[1]) begin
                                dir_d = DirUp;
                            end
                        end
                    end
                    default: q_d = q_q;
                endcase
            end else begin
                cnt_d = cnt_q + BITS_NUM'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            cnt_q   <= '0;
            q_q     <= PAT_INIT;
            mode_q  <= MODE_STOP;
            speed_q <= SPEED_MIN;
            tick_q  <= 1'b0;
            dir_q   <= DirUp;
        end else begin
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            tick_q  <= tick_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        Q     = q_q;
        MODE  = mode_q;
        SPEED = speed_q;
        TICK  = tick_q;
    end

endmodule

// File: tb/tb_krazace_seq.sv
// Directed bench for krazace_seq with a cycle-level behavioural model and literal pins.
module tb_krazace_seq;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       CE;
    logic       BTN_MODE;
    logic       BTN_FAST;
    logic       BTN_SLOW;
    logic [3:0] Q;
    logic [1:0] MODE;
    logic [2:0] SPEED;
    logic       TICK;

    int errors = 0;
    int checks = 0;

    krazace_seq #(
        .BITS_NUM (27),
        .MOD_BASE (2)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .CE       (CE),
        .BTN_MODE (BTN_MODE),
        .BTN_FAST (BTN_FAST),
        .BTN_SLOW (BTN_SLOW),
        .Q        (Q),
        .MODE     (MODE),
        .SPEED    (SPEED),
        .TICK     (TICK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pattern held as a position (LEFT/RIGHT) or a phase through the bounce walk.
    int         m_cnt, m_pos, m_phase, m_speed;
    logic [1:0] m_mode;
    logic       m_tick;
    logic       pm, pf, ps;
    bit         model_ok = 0;
    int         btbl[6] = '{0, 1, 2, 3, 2, 1};

    function automatic int model_q();
        if (m_mode == 2'd3) return 1 << btbl[m_phase];
        return 1 << m_pos;
    endfunction

    always @(posedge CLK) begin
        logic em, ef, es;
        if (CLR) begin
            m_mode = 0; m_speed = 0; m_cnt = 0; m_pos = 0; m_phase = 0; m_tick = 0;
            pm = 1; pf = 1; ps = 1;
            model_ok = 1;
        end else begin
            em = BTN_MODE && !pm;
            ef = BTN_FAST && !pf;
            es = BTN_SLOW && !ps;
            pm = BTN_MODE; pf = BTN_FAST; ps = BTN_SLOW;
            m_tick = 0;
            if (em) begin
                m_mode = m_mode + 2'd1;
                m_cnt = 0; m_pos = 0; m_phase = 0;
            end else if (m_mode != 0 && CE) begin
                if (m_cnt + 1 >= 2 * (8 - m_speed)) begin
                    m_cnt = 0;
                    m_tick = 1;
                    if (m_mode == 2'd1) m_pos = (m_pos + 1) % 4;
                    else if (m_mode == 2'd2) m_pos = (m_pos + 3) % 4;
                    else m_phase = (m_phase + 1) % 6;
                end else begin
                    m_cnt++;
                end
            end
            if (ef && !es && m_speed < 7) m_speed++;
            if (es && !ef && m_speed > 0) m_speed--;
        end
    end

    always @(negedge CLK) begin
        if (model_ok) begin
            chk("model_Q", int'(Q), model_q());
            chk("model_MODE", int'(MODE), int'(m_mode));
            chk("model_SPEED", int'(SPEED), m_speed);
            chk("model_TICK", int'(TICK), int'(m_tick));
        end
    end

    task automatic press(input logic m, input logic f, input logic s);
        BTN_MODE = m; BTN_FAST = f; BTN_SLOW = s;
        @(negedge CLK);
        BTN_MODE = 0; BTN_FAST = 0; BTN_SLOW = 0;
        @(negedge CLK);
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!TICK && cyc < 100);
    endtask

    task automatic expect_steps(input string name, input logic [3:0] exp[], input int per);
        int cyc;
        foreach (exp[i]) begin
            wait_tick(cyc);
            chk({name, "_q"}, int'(Q), int'(exp[i]));
            chk({name, "_period"}, cyc, per);
        end
    endtask

    initial begin
        int         cyc;
        logic [3:0] saved;
        logic [3:0] left_seq[]   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] right_seq[]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        logic [3:0] bounce_seq[] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                     4'b0010, 4'b0001, 4'b0010, 4'b0100};

        CLR = 1; CE = 0; BTN_MODE = 0; BTN_FAST = 0; BTN_SLOW = 0;
        repeat (2) @(negedge CLK);
        CLR = 0;
        chk("reset_Q", int'(Q), 1);
        chk("reset_MODE", int'(MODE), 0);
        chk("reset_SPEED", int'(SPEED), 0);
        chk("reset_TICK", int'(TICK), 0);
        @(negedge CLK);

        // LEFT at full speed
        press(1, 0, 0);
        chk("left_MODE", int'(MODE), 1);
        repeat (7) press(0, 1, 0);
        chk("left_SPEED", int'(SPEED), 7);
        CE = 1;
        expect_steps("left", left_seq, 2);

        // CE freeze mid-period
        @(negedge CLK);
        CE = 0;
        saved = Q;
        repeat (10) begin
            @(negedge CLK);
            chk("freeze_TICK", int'(TICK), 0);
            chk("freeze_Q", int'(Q), int'(saved));
        end
        CE = 1;
        wait_tick(cyc);
        chk("resume_period", cyc, 1);
        chk("resume_Q", int'(Q), 4'b0010);

        // RIGHT
        CE = 0;
        press(1, 0, 0);
        chk("right_Q", int'(Q), 1);
        chk("right_MODE", int'(MODE), 2);
        CE = 1;
        expect_steps("right", right_seq, 2);

        // BOUNCE, ending at 0100, then reset with BTN_MODE held across release
        CE = 0;
        press(1, 0, 0);
        chk("bounce_Q", int'(Q), 1);
        chk("bounce_MODE", int'(MODE), 3);
        CE = 1;
        expect_steps("bounce", bounce_seq, 2);
        CLR = 1; BTN_MODE = 1;
        @(negedge CLK);
        chk("clr_Q", int'(Q), 1);
        chk("clr_MODE", int'(MODE), 0);
        chk("clr_SPEED", int'(SPEED), 0);
        CLR = 0;
        repeat (3) @(negedge CLK);
        BTN_MODE = 0;
        repeat (2) @(negedge CLK);
        chk("held_MODE", int'(MODE), 0);

        // Speed limits
        press(0, 0, 1);
        chk("slow_sat", int'(SPEED), 0);
        repeat (3) press(0, 1, 0);
        chk("speed3", int'(SPEED), 3);
        press(0, 1, 1);
        chk("fast_slow_same", int'(SPEED), 3);
        repeat (9) press(0, 1, 0);
        chk("fast_sat", int'(SPEED), 7);
        repeat (7) press(0, 0, 1);
        chk("speed0", int'(SPEED), 0);
        CE = 0;
        press(1, 0, 0);
        CE = 1;
        wait_tick(cyc);
        chk("slow_period1", cyc, 16);
        chk("slow_q1", int'(Q), 4'b0010);
        wait_tick(cyc);
        chk("slow_period2", cyc, 16);
        chk("slow_q2", int'(Q), 4'b0100);

        // Back to STOP with CE high
        repeat (3) press(1, 0, 0);
        chk("stop_MODE", int'(MODE), 0);
        repeat (30) begin
            @(negedge CLK);
            chk("stop_TICK", int'(TICK), 0);
            chk("stop_Q", int'(Q), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
